// File: rtl/result_bus_broadcaster_pkg.sv
// result_bus_broadcaster_pkg
//   Shared helpers for the result bus broadcaster slice.
//   wrap_add : circular index add used by the round-robin scan.
package result_bus_broadcaster_pkg;

   // base and step are both below n, so a single conditional subtract wraps
   function automatic int wrap_add(input int base, input int step, input int n);
      int s;
      s = base + step;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/result_bus_broadcaster_if.sv
// result_bus_broadcaster_if
//   Handshake and broadcast bundle between the functional units, the
//   broadcaster, and the reservation-station snoopers.
//   unit_valid/unit_source/unit_value : unit -> broadcaster offer
//   unit_ready                        : broadcaster -> unit accept
//   bus_asserted/bus_source/bus_value : broadcast triples, one per bus
//   master : producer/snooper side      slave : broadcaster side
interface result_bus_broadcaster_if #(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 1,
   parameter int BUS_COUNT          = 1,
   parameter int UNIT_COUNT         = 2
);
   logic [UNIT_COUNT-1:0]                    unit_valid;
   logic [UNIT_COUNT*STATION_INDEX_SIZE-1:0] unit_source;
   logic [UNIT_COUNT*SIZE-1:0]               unit_value;
   logic [UNIT_COUNT-1:0]                    unit_ready;
   logic [BUS_COUNT-1:0]                     bus_asserted;
   logic [BUS_COUNT*STATION_INDEX_SIZE-1:0]  bus_source;
   logic [BUS_COUNT*SIZE-1:0]                bus_value;

   modport master (
      output unit_valid, unit_source, unit_value,
      input  unit_ready, bus_asserted, bus_source, bus_value
   );

   modport slave (
      input  unit_valid, unit_source, unit_value,
      output unit_ready, bus_asserted, bus_source, bus_value
   );
endinterface

// File: rtl/result_bus_broadcaster_result_slot.sv
// result_slot
//   One-entry holding register for a single functional unit's result.
//   i_valid        : unit offers a result
//   i_grant        : arbiter has put this slot on a bus this cycle
//   i_tag/i_value  : offered tag and value
//   o_ready        : slot accepts this cycle (empty, or draining now)
//   o_pending/o_tag/o_value : held result
module result_slot
   import result_bus_broadcaster_pkg::*;
#(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          i_valid,
   input  logic                          i_grant,
   input  logic [STATION_INDEX_SIZE-1:0] i_tag,
   input  logic [SIZE-1:0]               i_value,
   output logic                          o_ready,
   output logic                          o_pending,
   output logic [STATION_INDEX_SIZE-1:0] o_tag,
   output logic [SIZE-1:0]               o_value
);
   logic                          r_pending;
   logic [STATION_INDEX_SIZE-1:0] r_tag;
   logic [SIZE-1:0]               r_value;
   logic                          w_load;

   // a slot being granted empties at this edge, so it can reload in the same cycle
   assign o_ready = reset & (~r_pending | i_grant);
   assign w_load  = i_valid & o_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_pending <= 1'b0;
         r_tag     <= '0;
         r_value   <= '0;
      end else if (w_load) begin
         r_pending <= 1'b1;
         r_tag     <= i_tag;
         r_value   <= i_value;
      end else if (i_grant) begin
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_tag     = r_tag;
   assign o_value   = r_value;
endmodule

// File: rtl/result_bus_broadcaster.sv
// result_bus_broadcaster
//   Collects tagged results from UNIT_COUNT units into one-entry slots and
//   round-robin broadcasts up to BUS_COUNT of them per cycle on registered
//   result buses.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : slave side of result_bus_broadcaster_if (unit handshakes + buses)
module result_bus_broadcaster
   import result_bus_broadcaster_pkg::*;
#(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 1,
   parameter int BUS_COUNT          = 1,
   parameter int UNIT_COUNT         = 2
) (
   input logic                     clock,
   input logic                     reset,
   result_bus_broadcaster_if.slave bus
);
   localparam int UW = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;

   logic [UNIT_COUNT-1:0]                         w_pending;
   logic [UNIT_COUNT-1:0]                         w_grant;
   logic [UNIT_COUNT-1:0]                         w_ready;
   logic [UNIT_COUNT-1:0][STATION_INDEX_SIZE-1:0] w_tag;
   logic [UNIT_COUNT-1:0][SIZE-1:0]               w_value;
   logic [BUS_COUNT-1:0]                          w_bus_hit;
   logic [BUS_COUNT-1:0][UW-1:0]                  w_bus_sel;
   logic [UW-1:0]                                 w_next_rr;

   logic [UW-1:0]                           r_rr;
   logic [BUS_COUNT-1:0]                    r_bus_asserted;
   logic [BUS_COUNT*STATION_INDEX_SIZE-1:0] r_bus_source;
   logic [BUS_COUNT*SIZE-1:0]               r_bus_value;

   for (genvar u = 0; u < UNIT_COUNT; u++) begin : g_slot
      result_slot #(
         .SIZE               (SIZE),
         .STATION_INDEX_SIZE (STATION_INDEX_SIZE)
      ) u_slot (
         .clock     (clock),
         .reset     (reset),
         .i_valid   (bus.unit_valid[u]),
         .i_grant   (w_grant[u]),
         .i_tag     (bus.unit_source[u*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]),
         .i_value   (bus.unit_value[u*SIZE +: SIZE]),
         .o_ready   (w_ready[u]),
         .o_pending (w_pending[u]),
         .o_tag     (w_tag[u]),
         .o_value   (w_value[u])
      );
   end

   assign bus.unit_ready = w_ready;

   // circular scan from rr; the n-th pending slot found takes bus n
   always_comb begin
      int n;
      int idx;
      n         = 0;
      idx       = 0;
      w_grant   = '0;
      w_bus_hit = '0;
      w_bus_sel = '0;
      w_next_rr = r_rr;
      for (int k = 0; k < UNIT_COUNT; k++) begin
         idx = wrap_add(int'(r_rr), k, UNIT_COUNT);
         if (w_pending[idx] && (n < BUS_COUNT)) begin
            w_grant[idx]   = 1'b1;
            w_bus_hit[n]   = 1'b1;
            w_bus_sel[n]   = UW'(idx);
            w_next_rr      = UW'(wrap_add(idx, 1, UNIT_COUNT));
            n              = n + 1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rr           <= '0;
         r_bus_asserted <= '0;
         r_bus_source   <= '0;
         r_bus_value    <= '0;
      end else begin
         r_rr <= w_next_rr;
         for (int j = 0; j < BUS_COUNT; j++) begin
            r_bus_asserted[j] <= w_bus_hit[j];
            r_bus_source[j*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] <=
               w_bus_hit[j] ? w_tag[w_bus_sel[j]] : '0;
            r_bus_value[j*SIZE +: SIZE] <=
               w_bus_hit[j] ? w_value[w_bus_sel[j]] : '0;
         end
      end
   end

   assign bus.bus_asserted = r_bus_asserted;
   assign bus.bus_source   = r_bus_source;
   assign bus.bus_value    = r_bus_value;
endmodule
